// File: rtl/prbs4_checker_if.sv
// Stream and status bundle between a PRBS4 word source and prbs4_checker.
// The source drives valid/data/clear and the checker reports lock and error status.
interface prbs4_checker_if #(
    parameter int unsigned ERR_CNT_WIDTH = 16
) ();
    logic                     valid_in;
    logic [3:0]               data_in;
    logic                     clear_in;
    logic                     locked_out;
    logic                     error_out;
    logic [ERR_CNT_WIDTH-1:0] error_count_out;

    modport master (
        output valid_in,
        output data_in,
        output clear_in,
        input  locked_out,
        input  error_out,
        input  error_count_out
    );

    modport slave (
        input  valid_in,
        input  data_in,
        input  clear_in,
        output locked_out,
        output error_out,
        output error_count_out
    );
endinterface

// File: rtl/prbs4_checker.sv
// Receive-side checker for the x^4+x+1 Galois PRBS4 word stream: self-synchronises,
// then flywheels an internal reference and counts mismatched words while locked.
module prbs4_checker #(
    parameter int unsigned LOCK_COUNT    = 8,
    parameter int unsigned LOSS_COUNT    = 4,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input logic             clk_in,
    input logic             rst_in,
    prbs4_checker_if.slave  bus
);
    typedef enum logic [0:0] {StSearch, StLocked} state_e;

    localparam logic [7:0]               LockTarget = 8'(LOCK_COUNT);
    localparam logic [7:0]               LossTarget = 8'(LOSS_COUNT);
    localparam logic [ERR_CNT_WIDTH-1:0] ErrOne     = ERR_CNT_WIDTH'(1);

    function automatic logic [3:0] prbs_step(input logic [3:0] q);
        return {q[2], q[1], q[0] ^ q[3], q[3]};
    endfunction

    state_e                   state_q;
    logic [3:0]               ref_q;
    logic                     have_ref_q;
    logic [7:0]               match_cnt_q;
    logic [7:0]               miss_cnt_q;
    logic                     error_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

    logic                     valid;
    logic [3:0]               data;
    logic                     clear;
    logic [3:0]               exp_word;
    logic [7:0]               match_next;
    logic [7:0]               miss_next;
    logic                     locked_miss;
    logic                     err_cnt_sat;

    assign valid       = bus.valid_in;
    assign data        = bus.data_in;
    assign clear       = bus.clear_in;
    assign exp_word    = prbs_step(ref_q);
    assign match_next  = match_cnt_q + 8'd1;
    assign miss_next   = miss_cnt_q + 8'd1;
    assign locked_miss = valid && (state_q == StLocked) && (data != exp_word);
    assign err_cnt_sat = &err_cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StSearch;
            ref_q       <= 4'd0;
            have_ref_q  <= 1'b0;
            match_cnt_q <= 8'd0;
            miss_cnt_q  <= 8'd0;
            error_q     <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            error_q <= 1'b0;
            if (valid) begin
                unique case (state_q)
                    StSearch: begin
                        // Every search word reloads ref so a new alignment is tried at once.
                        ref_q <= data;
                        if (!have_ref_q || (data == 4'd0)) begin
                            have_ref_q  <= (data != 4'd0);
                            match_cnt_q <= 8'd0;
                        end else if (data == exp_word) begin
                            match_cnt_q <= match_next;
                            if (match_next == LockTarget) begin
                                state_q    <= StLocked;
                                miss_cnt_q <= 8'd0;
                            end
                        end else begin
                            match_cnt_q <= 8'd0;
                        end
                    end
                    StLocked: begin
                        // Flywheel: received data never reloads ref while locked.
                        ref_q <= exp_word;
                        if (data == exp_word) begin
                            miss_cnt_q <= 8'd0;
                        end else begin
                            error_q    <= 1'b1;
                            miss_cnt_q <= miss_next;
                            if (miss_next == LossTarget) begin
                                state_q     <= StSearch;
                                have_ref_q  <= 1'b0;
                                match_cnt_q <= 8'd0;
                                miss_cnt_q  <= 8'd0;
                            end
                        end
                    end
                    default: state_q <= StSearch;
                endcase
            end

            if (clear) begin
                err_cnt_q <= '0;
            end else if (locked_miss && !err_cnt_sat) begin
                err_cnt_q <= err_cnt_q + ErrOne;
            end
        end
    end

    assign bus.locked_out      = (state_q == StLocked);
    assign bus.error_out       = error_q;
    assign bus.error_count_out = err_cnt_q;
endmodule
